ttl_bus_reader: RTL and testbench

Read sequencer for a shared tri-state data bus driven by up to NSRC octal registered drivers, each with an active-low output enable. On a request it releases the bus for a guard interval, then enables exactly one driver for a settle interval. It captures the bus on the last settle edge and returns the word with a one-cycle valid pulse. It sits between the CPU control logic and the bus-side register bank, and is the only block allowed to drive the drivers' OE_bar lines.

---
 rtl/ttl_bus_reader.sv | 125 ++++++++++++
 tb/tb_ttl_bus_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_bus_reader.sv
// rtl/ttl_bus_reader.sv - read sequencer for a shared tri-state bus with registered OE_bar drivers
module ttl_bus_reader #(
  parameter int WIDTH  = 8,
  parameter int NSRC   = 6,
  parameter int SELW   = 3,
  parameter int GUARD  = 1,
  parameter int SETTLE = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req,
  input  logic [SELW-1:0]  req_sel,
  output logic             req_ready,
  output logic [NSRC-1:0]  oe_bar,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             err
);

  localparam int CNT_MAX = (GUARD > SETTLE) ? GUARD : SETTLE;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] GUARD_LOAD  = CNTW'(GUARD > 0 ? GUARD - 1 : 0);
  localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE - 1);
  localparam logic [SELW:0]   NSRC_L      = NSRC[SELW:0];

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_DRIVE} state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             oor_q, oor_d;
  logic [NSRC-1:0]  oe_d;
  logic [WIDTH-1:0] data_d;
  logic             valid_d, err_d;
  logic             accept, req_oor;

  // Out-of-range selects yield an all-high mask, so no driver is ever enabled.
  function automatic logic [NSRC-1:0] enable_mask(input logic [SELW-1:0] sel, input logic oor);
    logic [NSRC-1:0] m;
    m = '1;
    for (int i = 0; i < NSRC; i++)
      if (!oor && sel == SELW'(i)) m[i] = 1'b0;
    return m;
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req & req_ready;
  assign req_oor   = ({1'b0, req_sel} >= NSRC_L);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    oor_d   = oor_q;
    oe_d    = oe_bar;
    data_d  = rd_data;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        oe_d = '1;
        if (accept) begin
          sel_d = req_sel;
          oor_d = req_oor;
          if (GUARD > 0) begin
            state_d = S_GUARD;
            cnt_d   = GUARD_LOAD;
          end else begin
            state_d = S_DRIVE;
            cnt_d   = SETTLE_LOAD;
            oe_d    = enable_mask(req_sel, req_oor);
          end
        end
      end
      S_GUARD: begin
        if (cnt_q == '0) begin
          state_d = S_DRIVE;
          cnt_d   = SETTLE_LOAD;
          oe_d    = enable_mask(sel_q, oor_q);
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          oe_d    = '1;
          valid_d = 1'b1;
          err_d   = oor_q;
          data_d  = oor_q ? '0 : bus_in;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        oe_d    = '1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      oor_q    <= 1'b0;
      oe_bar   <= '1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      oor_q    <= oor_d;
      oe_bar   <= oe_d;
      rd_data  <= data_d;
      rd_valid <= valid_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_ttl_bus_reader.sv
// tb/tb_ttl_bus_reader.sv - self-checking bench for ttl_bus_reader (default and GUARD=0/SETTLE=1 builds)
module tb_ttl_bus_reader;
  localparam int WIDTH = 8;
  localparam int NSRC  = 6;
  localparam int SELW  = 3;
  localparam int G     = 1;
  localparam int S     = 2;

  logic             CLK, RST;
  logic             req, req_b;
  logic [SELW-1:0]  req_sel, req_sel_b;
  logic             req_ready, req_ready_b;
  logic [NSRC-1:0]  oe_bar, oe_bar_b;
  logic [WIDTH-1:0] bus_in, bus_in_b, rd_data, rd_data_b;
  logic             rd_valid, rd_valid_b, err, err_b;

  logic [WIDTH-1:0] src_val [8];
  logic [WIDTH-1:0] float_val;

  int checks, failures, cyc, acc_e, acc_s;
  bit busy;
  logic [WIDTH-1:0] exp_data;

  ttl_bus_reader #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .GUARD(G), .SETTLE(S)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_sel(req_sel), .req_ready(req_ready),
    .oe_bar(oe_bar), .bus_in(bus_in), .rd_data(rd_data), .rd_valid(rd_valid), .err(err));

  ttl_bus_reader #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .GUARD(0), .SETTLE(1)) dut_b (
    .CLK(CLK), .RST(RST), .req(req_b), .req_sel(req_sel_b), .req_ready(req_ready_b),
    .oe_bar(oe_bar_b), .bus_in(bus_in_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .err(err_b));

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // Bus model: an enabled driver wins, otherwise the bus carries junk.
  always_comb begin
    bus_in = float_val;
    for (int i = 0; i < NSRC; i++) if (!oe_bar[i]) bus_in = src_val[i];
  end
  always_comb begin
    bus_in_b = float_val;
    for (int i = 0; i < NSRC; i++) if (!oe_bar_b[i]) bus_in_b = src_val[i];
  end

  // One clock edge: advance the reference timeline, then compare 1 time unit later.
  task automatic tick();
    logic [NSRC-1:0]  exp_oe;
    logic             exp_rv, exp_err, exp_rdy;
    int n, k;
    @(posedge CLK);
    n = cyc;
    cyc++;
    exp_oe = '1; exp_rv = 0; exp_err = 0; exp_rdy = 1;
    if (RST) begin
      busy = 0;
      exp_data = '0;
    end else begin
      if (!busy && req) begin
        busy = 1; acc_e = n; acc_s = int'(req_sel);
      end
      if (busy) begin
        k = n - acc_e;
        exp_rdy = (k >= G + S);
        if (k >= G && k < G + S && acc_s < NSRC) exp_oe[acc_s] = 1'b0;
        if (k == G + S) begin
          exp_rv   = 1;
          exp_err  = (acc_s >= NSRC);
          exp_data = (acc_s < NSRC) ? src_val[acc_s] : '0;
          busy     = 0;
        end
      end
    end
    #1;
    checks++;
    if (oe_bar !== exp_oe) begin failures++; $display("FAIL oe_bar edge=%0d got=%b exp=%b", n, oe_bar, exp_oe); end
    checks++;
    if (rd_valid !== exp_rv) begin failures++; $display("FAIL rd_valid edge=%0d got=%b exp=%b", n, rd_valid, exp_rv); end
    checks++;
    if (err !== exp_err) begin failures++; $display("FAIL err edge=%0d got=%b exp=%b", n, err, exp_err); end
    checks++;
    if (rd_data !== exp_data) begin failures++; $display("FAIL rd_data edge=%0d got=%h exp=%h", n, rd_data, exp_data); end
    checks++;
    if (req_ready !== exp_rdy) begin failures++; $display("FAIL req_ready edge=%0d got=%b exp=%b", n, req_ready, exp_rdy); end
    checks++;
    if ($countones(~oe_bar) > 1) begin failures++; $display("FAIL oe_onehot edge=%0d got=%b exp=at_most_one_low", n, oe_bar); end
    float_val = WIDTH'($urandom);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #($urandom_range(1, 3));
    RST = 1;
    #1;
    checks++;
    if (oe_bar !== '1 || rd_valid !== 1'b0 || err !== 1'b0 || rd_data !== '0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got oe=%b rv=%b err=%b data=%h rdy=%b exp oe=111111 rv=0 err=0 data=00 rdy=1",
               oe_bar, rd_valid, err, rd_data, req_ready);
    end
    busy = 0;
    exp_data = '0;
    tick();
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (2) tick();
    @(negedge CLK);
    RST = 0;
    src_val[4] = 8'h5C;
    req = 1; req_sel = 3'd4;
    tick();
    req = 0;
    repeat (4) tick();
    do_reset();
  endtask

  task automatic test_single();
    src_val[2] = 8'hA5;
    req = 1; req_sel = 3'd2;
    tick();
    req = 0; req_sel = SELW'($urandom);
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    src_val[0] = 8'h11;
    src_val[5] = 8'hEE;
    req = 1; req_sel = 3'd0;
    tick();
    req_sel = 3'd5;
    repeat (4) tick();
    req = 0;
    repeat (4) tick();
  endtask

  task automatic test_out_of_range();
    req = 1; req_sel = 3'd7;
    tick();
    req = 0;
    repeat (4) tick();
  endtask

  task automatic test_reset_drive();
    do_reset();
    src_val[3] = 8'h3C;
    req = 1; req_sel = 3'd3;
    tick();
    req = 0;
    tick();
    do_reset();
    repeat (4) tick();
    req = 1; req_sel = 3'd3;
    tick();
    req = 0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      req = ($urandom_range(0, 3) != 0);
      req_sel = SELW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) src_val[$urandom_range(0, 7)] = WIDTH'($urandom);
      if ($urandom_range(0, 40) == 0) do_reset();
      tick();
    end
    req = 0;
    repeat (4) tick();
  endtask

  task automatic test_sweep();
    logic [NSRC-1:0]  m;
    logic [WIDTH-1:0] v;
    int s;
    req_b = 1;
    for (int r = 0; r < 3; r++) begin
      s = $urandom_range(0, NSRC - 1);
      v = WIDTH'($urandom);
      src_val[s] = v;
      req_sel_b = SELW'(s);
      m = '1; m[s] = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (oe_bar_b !== m || rd_valid_b !== 1'b0 || req_ready_b !== 1'b0) begin
        failures++;
        $display("FAIL sweep_drive r=%0d got oe=%b rv=%b rdy=%b exp oe=%b rv=0 rdy=0", r, oe_bar_b, rd_valid_b, req_ready_b, m);
      end
      req_sel_b = SELW'($urandom);
      @(posedge CLK); #1;
      checks++;
      if (oe_bar_b !== '1 || rd_valid_b !== 1'b1 || err_b !== 1'b0 || rd_data_b !== v || req_ready_b !== 1'b1) begin
        failures++;
        $display("FAIL sweep_capture r=%0d got oe=%b rv=%b err=%b data=%h rdy=%b exp oe=111111 rv=1 err=0 data=%h rdy=1",
                 r, oe_bar_b, rd_valid_b, err_b, rd_data_b, req_ready_b, v);
      end
    end
    req_b = 0;
    @(posedge CLK); #1;
    checks++;
    if (rd_valid_b !== 1'b0 || oe_bar_b !== '1) begin
      failures++;
      $display("FAIL sweep_idle got rv=%b oe=%b exp rv=0 oe=111111", rd_valid_b, oe_bar_b);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; busy = 0; acc_e = 0; acc_s = 0;
    exp_data = '0; float_val = '0;
    RST = 1; req = 0; req_sel = '0; req_b = 0; req_sel_b = '0;
    for (int i = 0; i < 8; i++) src_val[i] = WIDTH'($urandom);
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_reset_drive();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
